deflect_port_alloc: RTL
=======================

Name: deflect_port_alloc

Overview:
- Per-router output port allocator for the bufferless deflection router; the consumer of the lookahead productive vectors that the per-port route computation units produce.
- Each cycle it ranks up to four incoming network flits by age, grants productive ports, ejects at most one flit, and deflects the rest.
- It also admits one local injection if a network output is still free.
- Results are registered, so the block forms the switch-allocation pipeline stage in front of the crossbar and link registers.

Parameters:
- DATA_W, 64, payload width per flit, carried opaquely.
- AGE_W, 8, flit age field width.
- CNT_W, 16, deflection statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  4  valid per network input, index 0=W 1=E 2=S 3=N
- in_age  in  4*AGE_W  age per input; slice i is for input i
- in_prod  in  4*NUM_PORT  productive vector per input; bit0 W, bit1 E, bit2 S, bit3 N, bit4 local
- in_data  in  4*DATA_W  payload per input
- inj_valid  in  1  local injection request
- inj_prod  in  NUM_PORT  productive vector of the injected flit
- inj_data  in  DATA_W  injected payload
- inj_ready  out  1  injection accepted this cycle (combinational)
- out_valid  out  4  registered valid per network output W/E/S/N
- out_age  out  4*AGE_W  registered age per output
- out_data  out  4*DATA_W  registered payload per output
- ej_valid  out  1  registered ejection valid
- ej_data  out  DATA_W  registered ejection payload
- defl_cnt  out  CNT_W  saturating count of deflected flits

Behaviour:
- Reset (asynchronous, active-low):
  - out_valid=0, ej_valid=0, defl_cnt=0, rr_ptr=0.
  - out_age, out_data and ej_data are all zero.
- Ranking:
  - Valid inputs are ordered by in_age descending; larger age means older and higher priority.
  - Equal ages are ordered by index distance from rr_ptr, i.e. (i - rr_ptr) mod 4 ascending.
  - Invalid inputs are not ranked.
- Allocation, done in rank order within one cycle:
  - If prod[4]=1 and ejection is still free, the flit takes ejection.
  - Otherwise the flit takes the lowest-index free network port whose prod bit is set.
  - Otherwise it is deflected to the lowest-index free network port.
  - A flit with prod=0 is deflected.
  - 4 inputs against 4 outputs, so every valid network flit is always placed; no drops.
- Injection:
  - inj_ready = inj_valid AND at least one network port is free after network allocation.
  - The injected flit takes the lowest-index free productive port, else the lowest-index free port.
  - inj_prod[4] is ignored; an injected flit never ejects.
  - The injected flit's age field is 0.
  - inj_ready has no dependency on the registered outputs; the injecting side may drop inj_valid freely.
- Latency:
  - A flit presented in cycle t appears on out_*/ej_* at the edge ending cycle t; exactly 1 cycle.
  - The output register loads every cycle; there is no stall input.
- Age update:
  - Every flit placed on a network output gets out_age = in_age+1, saturating at 2^AGE_W-1.
  - Injected flits leave with age 1.
  - ej_data carries no age.
- Deflection counting:
  - A flit is "deflected" if its assigned port is not in its prod vector; this includes the injected flit.
  - defl_cnt += number deflected (0..4) per cycle, saturating at 2^CNT_W-1.
- rr_ptr:
  - 2-bit register, +1 mod 4 in every cycle with ≥1 deflection, else held.
- Reset asserted mid-traffic clears all in-flight registered flits immediately; no partial output is produced.

Decomposition:
- Shared package/global include: NUM_PORT, port index constants (PORT_W=0, PORT_E=1, PORT_S=2, PORT_N=3, PORT_L=4), and AGE_W default.
- One natural sub-module, age_rank4: combinational 4-input sorter.
  - Inputs: valids, ages, rr_ptr.
  - Output: rank-ordered index list.
  - Allocation, injection and registers stay in the top.

Test Plan:
- Single flit: in_valid=0001, age 5, prod=00010 → next cycle out_valid=0010 (E), out_age[E]=6, defl_cnt=0, inj_ready=inj_valid.
- Conflict: inputs 0 and 1 both prod=01000, ages 9 and 3 → input0 gets N, input1 gets W (deflected); defl_cnt=1, rr_ptr=1.
- Equal-age tie: inputs 0 and 2 both age 4, prod=00100, rr_ptr=2 → input2 gets S, input0 deflected to W.
- Double eject: inputs 1 and 3 prod=10000, ages 7 and 2 → ej_data=input1 payload; input3 on W as deflected; defl_cnt=1.
- Full load with injection: in_valid=1111, inj_valid=1 → inj_ready=0. Then with in_valid=0111 → inj_ready=1 and the injected flit's age is 1 at the output.
- Saturation and reset: age 255 → out_age 255. Force defl_cnt to 65535 and deflect → holds 65535. Drop reset mid-stream → all valids 0 asynchronously.

Source files
------------

// File: rtl/deflect_port_alloc_pkg.sv
// Shared definitions for the deflection-router output port allocator.
// Contents:
//   NUM_PORT      - router ports including the local port (W, E, S, N, L)
//   NUM_NET       - network ports / network inputs
//   PORT_*        - bit positions inside a productive-port vector
//   AGE_W_DEFAULT - default flit age width
//   port_idx_t    - index of one network port/input
//   lowest_set    - one-hot of the least significant set bit of a 4-bit mask
package deflect_port_alloc_pkg;

    localparam int NUM_PORT      = 5;
    localparam int NUM_NET       = 4;
    localparam int PORT_W        = 0;
    localparam int PORT_E        = 1;
    localparam int PORT_S        = 2;
    localparam int PORT_N        = 3;
    localparam int PORT_L        = 4;
    localparam int AGE_W_DEFAULT = 8;

    typedef logic [1:0] port_idx_t;

    // v & -v isolates the lowest set bit; an all-zero mask gives all-zero.
    function automatic logic [3:0] lowest_set(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/deflect_port_alloc_age_rank4.sv
// Combinational 4-input age sorter.
// Ports:
//   valid_i    - valid per input
//   age_i      - packed ages, slice i belongs to input i
//   rr_ptr_i   - tie-break origin; equal ages rank by (i - rr_ptr) mod 4
//   rank_idx_o - packed list of input indices, slice r holds rank r
//   rank_vld_o - rank r holds a valid input
// Valid inputs always occupy ranks 0..n-1 contiguously, because the
// age/distance key forms a strict total order (distances are distinct).
module deflect_port_alloc_age_rank4
    import deflect_port_alloc_pkg::*;
#(
    parameter int AGE_W = AGE_W_DEFAULT
) (
    input  logic [3:0]         valid_i,
    input  logic [4*AGE_W-1:0] age_i,
    input  port_idx_t          rr_ptr_i,
    output logic [7:0]         rank_idx_o,
    output logic [3:0]         rank_vld_o
);

    logic [AGE_W-1:0] age_a  [NUM_NET];
    port_idx_t        dist_a [NUM_NET];
    logic [2:0]       rank_a [NUM_NET];

    for (genvar gi = 0; gi < NUM_NET; gi++) begin : g_split
        assign age_a[gi]  = age_i[gi*AGE_W +: AGE_W];
        assign dist_a[gi] = 2'(gi) - rr_ptr_i;
    end

    // Rank of input i = number of valid inputs that beat it.
    always_comb begin
        for (int i = 0; i < NUM_NET; i++) begin
            rank_a[i] = '0;
            for (int j = 0; j < NUM_NET; j++) begin
                if (j != i && valid_i[j] &&
                    ((age_a[j] > age_a[i]) ||
                     (age_a[j] == age_a[i] && dist_a[j] < dist_a[i]))) begin
                    rank_a[i] = rank_a[i] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        rank_idx_o = '0;
        rank_vld_o = '0;
        for (int r = 0; r < NUM_NET; r++) begin
            for (int i = 0; i < NUM_NET; i++) begin
                if (valid_i[i] && rank_a[i] == 3'(r)) begin
                    rank_idx_o[2*r +: 2] = 2'(i);
                    rank_vld_o[r]        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/deflect_port_alloc.sv
// Output port allocator of the bufferless deflection router (switch
// allocation stage). Ranks network flits by age, ejects at most one,
// grants productive ports, deflects the rest and admits one local
// injection into any port left free. Results are registered (1 cycle).
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   in_valid_i/age/prod/data_i - four network inputs (0=W 1=E 2=S 3=N)
//   inj_valid_i/prod/data_i    - local injection request
//   inj_ready_o          - injection accepted this cycle (combinational)
//   out_valid/age/data_o - registered network outputs W/E/S/N
//   ej_valid_o/ej_data_o - registered ejection
//   defl_cnt_o           - saturating deflected-flit counter
module deflect_port_alloc
    import deflect_port_alloc_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int AGE_W  = AGE_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [3:0]                in_valid_i,
    input  logic [4*AGE_W-1:0]        in_age_i,
    input  logic [4*NUM_PORT-1:0]     in_prod_i,
    input  logic [4*DATA_W-1:0]       in_data_i,
    input  logic                      inj_valid_i,
    input  logic [NUM_PORT-1:0]       inj_prod_i,
    input  logic [DATA_W-1:0]         inj_data_i,
    output logic                      inj_ready_o,
    output logic [3:0]                out_valid_o,
    output logic [4*AGE_W-1:0]        out_age_o,
    output logic [4*DATA_W-1:0]       out_data_o,
    output logic                      ej_valid_o,
    output logic [DATA_W-1:0]         ej_data_o,
    output logic [CNT_W-1:0]          defl_cnt_o
);

    logic [AGE_W-1:0]    age_a  [NUM_NET];
    logic [NUM_PORT-1:0] prod_a [NUM_NET];
    logic [DATA_W-1:0]   data_a [NUM_NET];

    logic [3:0]        out_valid_q, out_valid_d;
    logic [AGE_W-1:0]  out_age_q  [NUM_NET];
    logic [AGE_W-1:0]  out_age_d  [NUM_NET];
    logic [DATA_W-1:0] out_data_q [NUM_NET];
    logic [DATA_W-1:0] out_data_d [NUM_NET];
    logic              ej_valid_q, ej_valid_d;
    logic [DATA_W-1:0] ej_data_q, ej_data_d;
    logic [CNT_W-1:0]  defl_cnt_q, defl_cnt_d;
    port_idx_t         rr_ptr_q, rr_ptr_d;

    logic [7:0]        rank_idx_w;
    logic [3:0]        rank_vld_w;

    logic [3:0]        free_ports, grant, cand;
    logic              ej_taken;
    logic [2:0]        ndefl;
    port_idx_t         idx;
    logic [CNT_W:0]    cnt_sum;

    // An injected flit never ejects, so its local bit is not consulted.
    logic              inj_prod_l_unused;
    assign inj_prod_l_unused = inj_prod_i[PORT_L];

    for (genvar gi = 0; gi < NUM_NET; gi++) begin : g_ports
        assign age_a[gi]  = in_age_i[gi*AGE_W +: AGE_W];
        assign prod_a[gi] = in_prod_i[gi*NUM_PORT +: NUM_PORT];
        assign data_a[gi] = in_data_i[gi*DATA_W +: DATA_W];
        assign out_age_o[gi*AGE_W +: AGE_W]    = out_age_q[gi];
        assign out_data_o[gi*DATA_W +: DATA_W] = out_data_q[gi];
    end

    deflect_port_alloc_age_rank4 #(.AGE_W(AGE_W)) u_rank (
        .valid_i    (in_valid_i),
        .age_i      (in_age_i),
        .rr_ptr_i   (rr_ptr_q),
        .rank_idx_o (rank_idx_w),
        .rank_vld_o (rank_vld_w)
    );

    always_comb begin
        free_ports  = 4'hF;
        grant       = '0;
        cand        = '0;
        ej_taken    = 1'b0;
        ndefl       = '0;
        idx         = '0;
        out_valid_d = '0;
        ej_valid_d  = 1'b0;
        ej_data_d   = '0;
        inj_ready_o = 1'b0;
        for (int p = 0; p < NUM_NET; p++) begin
            out_age_d[p]  = '0;
            out_data_d[p] = '0;
        end

        // Walk flits oldest first; each takes ejection, a productive port,
        // or the lowest free port. Four flits on four ports never starve.
        for (int r = 0; r < NUM_NET; r++) begin
            idx   = rank_idx_w[2*r +: 2];
            grant = '0;
            if (rank_vld_w[r]) begin
                if (prod_a[idx][PORT_L] && !ej_taken) begin
                    ej_taken   = 1'b1;
                    ej_valid_d = 1'b1;
                    ej_data_d  = data_a[idx];
                end else begin
                    cand = free_ports & prod_a[idx][PORT_N:PORT_W];
                    if (cand != 4'd0) begin
                        grant = lowest_set(cand);
                    end else begin
                        grant = lowest_set(free_ports);
                        ndefl = ndefl + 3'd1;
                    end
                end
            end
            free_ports = free_ports & ~grant;
            for (int p = 0; p < NUM_NET; p++) begin
                if (grant[p]) begin
                    out_valid_d[p] = 1'b1;
                    out_age_d[p]   = (age_a[idx] == {AGE_W{1'b1}}) ? age_a[idx]
                                                                   : age_a[idx] + 1'b1;
                    out_data_d[p]  = data_a[idx];
                end
            end
        end

        // Injection uses whatever the network flits left over; it enters
        // with age 0 and therefore leaves with age 1.
        if (inj_valid_i && free_ports != 4'd0) begin
            inj_ready_o = 1'b1;
            cand = free_ports & inj_prod_i[PORT_N:PORT_W];
            if (cand != 4'd0) begin
                grant = lowest_set(cand);
            end else begin
                grant = lowest_set(free_ports);
                ndefl = ndefl + 3'd1;
            end
            for (int p = 0; p < NUM_NET; p++) begin
                if (grant[p]) begin
                    out_valid_d[p] = 1'b1;
                    out_age_d[p]   = AGE_W'(1);
                    out_data_d[p]  = inj_data_i;
                end
            end
        end
    end

    assign cnt_sum    = {1'b0, defl_cnt_q} + {{(CNT_W-2){1'b0}}, ndefl};
    assign defl_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    assign rr_ptr_d   = (ndefl != 3'd0) ? rr_ptr_q + 2'd1 : rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= '0;
            for (int p = 0; p < NUM_NET; p++) begin
                out_age_q[p]  <= '0;
                out_data_q[p] <= '0;
            end
            ej_valid_q <= 1'b0;
            ej_data_q  <= '0;
            defl_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            for (int p = 0; p < NUM_NET; p++) begin
                out_age_q[p]  <= out_age_d[p];
                out_data_q[p] <= out_data_d[p];
            end
            ej_valid_q <= ej_valid_d;
            ej_data_q  <= ej_data_d;
            defl_cnt_q <= defl_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign ej_valid_o  = ej_valid_q;
    assign ej_data_o   = ej_data_q;
    assign defl_cnt_o  = defl_cnt_q;

endmodule
